// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU issue port (src 0)
// and the load/store result port (src 1). Each source has a one-entry holding
// register; a round-robin arbiter grants one entry per cycle onto registered
// CDB outputs.
// Optional feature macro: CDB_ARB_FLUSH_EN adds a `flush` input that empties
// both holds, idles the bus and resets the round-robin pointer.
module cdb_arbiter #(
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RSNUM_W  = 3,
    parameter int TAG_FREE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CDB_ARB_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [TAG_W-1:0]   alu_tag,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic [RSNUM_W-1:0] alu_rsnum,
    input  logic [ADDR_W-1:0]  alu_offset,
    input  logic               alu_pc_valid,
    input  logic               ls_valid,
    output logic               ls_ready,
    input  logic [TAG_W-1:0]   ls_tag,
    input  logic [DATA_W-1:0]  ls_data,
    output logic               cdb_valid,
    output logic               cdb_src,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [DATA_W-1:0]  cdb_data,
    output logic [RSNUM_W-1:0] cdb_rsnum,
    output logic [ADDR_W-1:0]  cdb_offset,
    output logic               cdb_pc_valid
);

    localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

    // kill: flush request, tied low when the flush feature is not built
    logic kill;
`ifdef CDB_ARB_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // holding register 0 (ALU)
    logic               h0_full;
    logic [TAG_W-1:0]   h0_tag;
    logic [DATA_W-1:0]  h0_data;
    logic [RSNUM_W-1:0] h0_rsnum;
    logic [ADDR_W-1:0]  h0_offset;
    logic               h0_pc_valid;

    // holding register 1 (LS)
    logic               h1_full;
    logic [TAG_W-1:0]   h1_tag;
    logic [DATA_W-1:0]  h1_data;

    // round-robin pointer: 0 = ALU preferred on contention, 1 = LS preferred
    logic rr;

    logic grant0, grant1;
    logic acc0, acc1;

    // Arbitration and ready: a hold can take a new result when it is empty
    // or is being drained this cycle, so each source sustains 1 result/cycle.
    always_comb begin
        grant0    = h0_full & (~h1_full | ~rr);
        grant1    = h1_full & (~h0_full |  rr);
        alu_ready = (~h0_full | grant0) & ~kill;
        ls_ready  = (~h1_full | grant1) & ~kill;
        // TAG_FREE results complete the handshake but are never stored
        acc0      = alu_valid & alu_ready & (alu_tag != FREE);
        acc1      = ls_valid  & ls_ready  & (ls_tag  != FREE);
    end

    // ALU hold: load on accept, clear on grant without a replacement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_full     <= 1'b0;
            h0_tag      <= FREE;
            h0_data     <= '0;
            h0_rsnum    <= '0;
            h0_offset   <= '0;
            h0_pc_valid <= 1'b0;
        end else if (kill) begin
            h0_full     <= 1'b0;
        end else if (acc0) begin
            h0_full     <= 1'b1;
            h0_tag      <= alu_tag;
            h0_data     <= alu_data;
            h0_rsnum    <= alu_rsnum;
            h0_offset   <= alu_offset;
            h0_pc_valid <= alu_pc_valid;
        end else if (grant0) begin
            h0_full     <= 1'b0;
        end
    end

    // LS hold: load on accept, clear on grant without a replacement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_full <= 1'b0;
            h1_tag  <= FREE;
            h1_data <= '0;
        end else if (kill) begin
            h1_full <= 1'b0;
        end else if (acc1) begin
            h1_full <= 1'b1;
            h1_tag  <= ls_tag;
            h1_data <= ls_data;
        end else if (grant1) begin
            h1_full <= 1'b0;
        end
    end

    // Round-robin pointer: after any grant, the other source is preferred
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (kill) begin
            rr <= 1'b0;
        end else if (grant0) begin
            rr <= 1'b1;
        end else if (grant1) begin
            rr <= 1'b0;
        end
    end

    // Registered CDB: winner's fields, or an idle bus (TAG_FREE, zeros)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid    <= 1'b0;
            cdb_src      <= 1'b0;
            cdb_tag      <= FREE;
            cdb_data     <= '0;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end else if (!kill && grant0) begin
            cdb_valid    <= 1'b1;
            cdb_src      <= 1'b0;
            cdb_tag      <= h0_tag;
            cdb_data     <= h0_data;
            cdb_rsnum    <= h0_rsnum;
            cdb_offset   <= h0_offset;
            cdb_pc_valid <= h0_pc_valid;
        end else if (!kill && grant1) begin
            cdb_valid    <= 1'b1;
            cdb_src      <= 1'b1;
            cdb_tag      <= h1_tag;
            cdb_data     <= h1_data;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end else begin
            cdb_valid    <= 1'b0;
            cdb_src      <= 1'b0;
            cdb_tag      <= FREE;
            cdb_data     <= '0;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven directed vectors for cdb_arbiter plus
// hand-written reset-mid-hold and (when built with CDB_ARB_FLUSH_EN) flush
// sequences. Each vector row is one clock cycle: inputs applied after the
// falling edge, ready/CDB outputs compared 1 ns later.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, alu_pc_valid;
    logic [4:0]  alu_tag;
    logic [31:0] alu_data, alu_offset;
    logic [2:0]  alu_rsnum;
    logic        ls_valid, ls_ready;
    logic [4:0]  ls_tag;
    logic [31:0] ls_data;
    logic        cdb_valid, cdb_src, cdb_pc_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_offset;
    logic [2:0]  cdb_rsnum;
`ifdef CDB_ARB_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef CDB_ARB_FLUSH_EN
        .flush        (flush),
`endif
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_tag      (alu_tag),
        .alu_data     (alu_data),
        .alu_rsnum    (alu_rsnum),
        .alu_offset   (alu_offset),
        .alu_pc_valid (alu_pc_valid),
        .ls_valid     (ls_valid),
        .ls_ready     (ls_ready),
        .ls_tag       (ls_tag),
        .ls_data      (ls_data),
        .cdb_valid    (cdb_valid),
        .cdb_src      (cdb_src),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_rsnum    (cdb_rsnum),
        .cdb_offset   (cdb_offset),
        .cdb_pc_valid (cdb_pc_valid)
    );

    // {alu_ready, ls_ready, valid, src, tag, data, rsnum, offset, pc_valid}
    logic [76:0] act;
    assign act = {alu_ready, ls_ready, cdb_valid, cdb_src, cdb_tag, cdb_data,
                  cdb_rsnum, cdb_offset, cdb_pc_valid};

    typedef struct {
        logic        av;
        logic [4:0]  at;
        logic [31:0] ad;
        logic [2:0]  ars;
        logic [31:0] aoff;
        logic        apc;
        logic        lv;
        logic [4:0]  lt;
        logic [31:0] ld;
        logic [76:0] exp;
    } vec_t;

    function automatic logic [76:0] pk(int ar, int lr, int cv, int cs, int tg,
                                       int dt, int rs, int off, int pc);
        return {1'(ar), 1'(lr), 1'(cv), 1'(cs), 5'(tg), 32'(dt), 3'(rs),
                32'(off), 1'(pc)};
    endfunction

    function automatic vec_t mk(int av, int at, int ad, int ars, int aoff, int apc,
                                int lv, int lt, int ld, logic [76:0] e);
        vec_t r;
        r.av = 1'(av);  r.at = 5'(at);  r.ad = 32'(ad);  r.ars = 3'(ars);
        r.aoff = 32'(aoff);  r.apc = 1'(apc);
        r.lv = 1'(lv);  r.lt = 5'(lt);  r.ld = 32'(ld);
        r.exp = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [76:0] a, input logic [76:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid = v.av;  alu_tag = v.at;  alu_data = v.ad;  alu_rsnum = v.ars;
        alu_offset = v.aoff;  alu_pc_valid = v.apc;
        ls_valid = v.lv;  ls_tag = v.lt;  ls_data = v.ld;
    endtask

    vec_t vecs[$];
    vec_t z;
    logic [76:0] idl;

    initial begin
        idl = pk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        z   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, idl);
        // contention: ALU tag4 + LS tag5 together
        vecs.push_back(mk(1, 4, 'h44, 1, 0, 0, 1, 5, 'h55, idl));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 0, 4, 'h44, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 5, 'h55, 0, 0, 0)));
        vecs.push_back(z);
        // single ALU result, two-edge latency
        vecs.push_back(mk(1, 3, 'h10, 2, 0, 0, 0, 0, 0, idl));
        vecs.push_back(z);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 0, 3, 'h10, 2, 0, 0)));
        vecs.push_back(z);
        // JALR redirect then an LS result
        vecs.push_back(mk(1, 6, 'h20, 3, 'h1FE, 1, 0, 0, 0, idl));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 'h77, idl));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 0, 6, 'h20, 3, 'h1FE, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 7, 'h77, 0, 0, 0)));
        vecs.push_back(z);
        // fairness: both valid six cycles, stalled fields held stable
        vecs.push_back(mk(1, 8, 'h8, 0, 0, 0, 1, 9, 'h9, idl));
        vecs.push_back(mk(1, 10, 'hA, 0, 0, 0, 1, 9, 'h9, pk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 10, 'hA, 0, 0, 0, 1, 11, 'hB, pk(0, 1, 1, 0, 8, 'h8, 0, 0, 0)));
        vecs.push_back(mk(1, 12, 'hC, 0, 0, 0, 1, 11, 'hB, pk(1, 0, 1, 1, 9, 'h9, 0, 0, 0)));
        vecs.push_back(mk(1, 12, 'hC, 0, 0, 0, 1, 13, 'hD, pk(0, 1, 1, 0, 10, 'hA, 0, 0, 0)));
        vecs.push_back(mk(1, 14, 'hE, 0, 0, 0, 1, 13, 'hD, pk(1, 0, 1, 1, 11, 'hB, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 12, 'hC, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 13, 'hD, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 0, 14, 'hE, 0, 0, 0)));
        vecs.push_back(z);
        // TAG_FREE offers are accepted and dropped
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 'h99, idl));
        vecs.push_back(z);
        vecs.push_back(z);
        vecs.push_back(mk(1, 0, 'h98, 1, 'h40, 1, 0, 0, 0, idl));
        vecs.push_back(z);
        vecs.push_back(z);

        // reset state
        rst_n = 1'b0;
        drive(z);
        repeat (2) @(negedge clk);
        #1 chk("reset_state", act, idl);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1 chk($sformatf("vec%0d", i), act, vecs[i].exp);
            @(negedge clk);
        end

        // reset asserted while the ALU hold is still full (pointer favours LS here)
        drive(mk(1, 3, 'h10, 2, 0, 0, 1, 5, 'h55, idl));
        @(negedge clk);
        drive(z);
        @(negedge clk);
        #1 chk("mid_ls_beat", act, pk(1, 1, 1, 1, 5, 'h55, 0, 0, 0));
        rst_n = 1'b0;
        #1 chk("rst_async", act, idl);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release", act, idl);
        @(negedge clk);
        #1 chk("rst_discard", act, idl);
        @(negedge clk);
        #1 chk("rst_discard2", act, idl);

`ifdef CDB_ARB_FLUSH_EN
        // flush over two full holds: nothing broadcast, pointer back to ALU
        @(negedge clk);
        drive(mk(1, 4, 'h44, 1, 0, 0, 1, 5, 'h55, idl));
        @(negedge clk);
        drive(z);
        flush = 1'b1;
        #1 chk("flush_ready", act, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_out", act, idl);
        @(negedge clk);
        #1 chk("flush_drain", act, idl);
        drive(mk(1, 8, 'h8, 1, 0, 0, 1, 9, 'h9, idl));
        @(negedge clk);
        drive(z);
        @(negedge clk);
        #1 chk("flush_rr_alu", act, pk(1, 1, 1, 0, 8, 'h8, 1, 0, 0));
        @(negedge clk);
        #1 chk("flush_rr_ls", act, pk(1, 1, 1, 1, 9, 'h9, 0, 0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
